counter_method_resp: RTL and testbench
======================================

COUNTER_METHOD_RESP -- requirements
Module: counter_method_resp

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits.
REQ-002 Parameter PRESCALE_W, default 21: prescaler width; one count step every 2^PRESCALE_W enabled cycles.
REQ-003 Parameter START_RUNNING, default 1: run state entered on reset release (1 = RUNNING, 0 = STOPPED).
REQ-004 CLK  in  1  single clock; all state on its rising edge.
REQ-005 RST  in  1  asynchronous, active-high reset.
REQ-006 EN_start  in  1  action method "start"; acts only when RDY_start is 1.
REQ-007 RDY_start  out  1  start method ready.
REQ-008 EN_stop  in  1  action method "stop"; acts only when RDY_stop is 1.
REQ-009 RDY_stop  out  1  stop method ready.
REQ-010 EN_load  in  1  action method "load"; acts only when RDY_load is 1.
REQ-011 load_value  in  WIDTH  argument of load.
REQ-012 RDY_load  out  1  load method ready.
REQ-013 count_value  out  WIDTH  value method: current count, registered.
REQ-014 RDY_count_value  out  1  value method ready; constant 1 outside reset.
REQ-015 tick  out  1  one-cycle pulse in the cycle count_value changes by stepping.

Function
REQ-016 Two-state FSM: STOPPED, RUNNING; RDY_start = RDY_load = (state==STOPPED); RDY_stop = (state==RUNNING).
REQ-017 EN_x asserted while RDY_x is 0 shall be ignored, no state change.
REQ-018 STOPPED + EN_start -> RUNNING next cycle; prescaler cleared to 0.
REQ-019 RUNNING + EN_stop -> STOPPED next cycle; prescaler cleared; count_value held.
REQ-020 STOPPED + EN_load: count_value = load_value next cycle.
REQ-021 EN_load and EN_start in same STOPPED cycle: both act; next cycle count_value = load_value, state RUNNING, prescaler 0.
REQ-022 Prescaler increments each RUNNING cycle, wraps modulo 2^PRESCALE_W, frozen in STOPPED.
REQ-023 When RUNNING and prescaler == all-ones: count_value increments by 1 next cycle and tick is 1 that next cycle; otherwise tick 0.
REQ-024 count_value wraps all-ones -> 0 with no stall.
REQ-025 EN_stop in the same cycle a step is due: stop wins, no step, no tick.
REQ-026 Latency: method effect visible exactly one cycle after EN sampled; RDY outputs are combinational from state only, never from EN inputs.

Reset
REQ-027 While RST is 1: count_value 0, prescaler 0, tick 0, RDY_count_value 0, state per START_RUNNING; RDY_start/RDY_stop/RDY_load forced 0.
REQ-028 RST assertion mid-operation shall clear state immediately without waiting for CLK; first step after release occurs 2^PRESCALE_W cycles later when RUNNING.

Configuration
REQ-029 Macro COUNTER_WRAP_FLAG_EN: when defined, add output wrapped (1 bit) and input EN_clear_wrap with output RDY_clear_wrap (constant 1 outside reset).
REQ-030 With COUNTER_WRAP_FLAG_EN: wrapped sets on a step from all-ones to 0, stays set until EN_clear_wrap; set and clear in same cycle -> set wins; reset value 0.
REQ-031 Without COUNTER_WRAP_FLAG_EN: those ports and the flag register are absent; all other behaviour identical.

Structure
REQ-032 Shared package holds the FSM state enum (STOPPED, RUNNING) and default parameter constants for WIDTH and PRESCALE_W.
REQ-033 One sub-module, counter_prescaler (enable, clear, wrap-pulse output), instantiated once; the counter itself stays in the top module.
REQ-034 No derived clocks: stepping uses a clock enable on CLK only.

Verification (WIDTH=4, PRESCALE_W=2, START_RUNNING=0 unless noted)
REQ-035 Reset release, EN_start one cycle -> count_value 1,2,3 at 4, 8, 12 cycles after start; tick pulses on those cycles only.
REQ-036 STOPPED, EN_load with load_value=4'hE plus EN_start same cycle -> E, then F, then 0 at 4-cycle intervals; wrapped=1 after the 0 step when macro defined.
REQ-037 RUNNING, EN_load=1 with load_value=4'h5 -> ignored, count unchanged; EN_start while RUNNING ignored.
REQ-038 EN_stop on the cycle a step is due -> no step, no tick; restart -> next step exactly 4 cycles later.
REQ-039 RST pulsed asynchronously between clock edges while count=7 -> count_value 0 and RDY outputs 0 before the next CLK edge.
REQ-040 START_RUNNING=1: after reset release with no method calls -> count_value 1 after 4 cycles; RDY_stop=1, RDY_start=0.

Source files
------------

// File: rtl/counter_method_resp_pkg.sv
// Shared types and default sizing for the method-style prescaled counter.
package counter_method_resp_pkg;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } run_state_e;

    localparam int unsigned DEFAULT_WIDTH      = 4;
    localparam int unsigned DEFAULT_PRESCALE_W = 21;

endpackage : counter_method_resp_pkg

// File: rtl/counter_method_resp_if.sv
// Method-call bundle (EN/RDY pairs, argument and value) of counter_method_resp.
// Wrap-flag signals exist only when COUNTER_WRAP_FLAG_EN is defined.
interface counter_method_resp_if #(
    parameter int unsigned WIDTH = counter_method_resp_pkg::DEFAULT_WIDTH
);
    logic             EN_start;
    logic             RDY_start;
    logic             EN_stop;
    logic             RDY_stop;
    logic             EN_load;
    logic [WIDTH-1:0] load_value;
    logic             RDY_load;
    logic [WIDTH-1:0] count_value;
    logic             RDY_count_value;
    logic             tick;
`ifdef COUNTER_WRAP_FLAG_EN
    logic             wrapped;
    logic             EN_clear_wrap;
    logic             RDY_clear_wrap;
`endif

    modport master (
        output EN_start, EN_stop, EN_load, load_value,
`ifdef COUNTER_WRAP_FLAG_EN
        output EN_clear_wrap,
        input  wrapped, RDY_clear_wrap,
`endif
        input  RDY_start, RDY_stop, RDY_load, count_value, RDY_count_value, tick
    );

    modport slave (
        input  EN_start, EN_stop, EN_load, load_value,
`ifdef COUNTER_WRAP_FLAG_EN
        input  EN_clear_wrap,
        output wrapped, RDY_clear_wrap,
`endif
        output RDY_start, RDY_stop, RDY_load, count_value, RDY_count_value, tick
    );

endinterface : counter_method_resp_if

// File: rtl/counter_method_resp_prescaler.sv
// Free-running prescaler: counts enabled cycles, flags the cycle it rolls over.
module counter_prescaler
    import counter_method_resp_pkg::*;
#(
    parameter int unsigned PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic wrap_c
);

    logic [PRESCALE_W-1:0] cnt;

    // Clear has priority so a start/stop always restarts a full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + PRESCALE_W'(1);
        end
    end

    assign wrap_c = enable && (cnt == '1);

endmodule : counter_prescaler

// File: rtl/counter_method_resp.sv
// Method-style (EN/RDY) prescaled up-counter with start/stop/load.
// Optional sticky wrap flag enabled by defining COUNTER_WRAP_FLAG_EN.
module counter_method_resp
    import counter_method_resp_pkg::*;
#(
    parameter int unsigned WIDTH         = DEFAULT_WIDTH,
    parameter int unsigned PRESCALE_W    = DEFAULT_PRESCALE_W,
    parameter bit          START_RUNNING = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    counter_method_resp_if.slave bus
);

    localparam run_state_e RESET_STATE = START_RUNNING ? RUNNING : STOPPED;

    run_state_e       state;
    logic [WIDTH-1:0] count;
    logic             tick_q;
    logic             start_fire;
    logic             stop_fire;
    logic             load_fire;
    logic             pre_wrap;
    logic             step;

    // Ready depends on state only; reset forces every method unready.
    assign bus.RDY_start       = !RST && (state == STOPPED);
    assign bus.RDY_load        = !RST && (state == STOPPED);
    assign bus.RDY_stop        = !RST && (state == RUNNING);
    assign bus.RDY_count_value = !RST;

    assign start_fire = bus.EN_start && bus.RDY_start;
    assign stop_fire  = bus.EN_stop  && bus.RDY_stop;
    assign load_fire  = bus.EN_load  && bus.RDY_load;

    // A stop in the step cycle suppresses that step.
    assign step = pre_wrap && !stop_fire;

    counter_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk    (CLK),
        .rst    (RST),
        .enable (state == RUNNING),
        .clear  (start_fire || stop_fire),
        .wrap_c (pre_wrap)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= RESET_STATE;
            count  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= step;
            case (state)
                STOPPED: if (start_fire) state <= RUNNING;
                RUNNING: if (stop_fire)  state <= STOPPED;
                default: state <= RESET_STATE;
            endcase
            if (load_fire) begin
                count <= bus.load_value;
            end else if (step) begin
                count <= count + WIDTH'(1);
            end
        end
    end

    assign bus.count_value = count;
    assign bus.tick        = tick_q;

`ifdef COUNTER_WRAP_FLAG_EN
    logic wrapped_q;

    assign bus.RDY_clear_wrap = !RST;

    // Setting on an all-ones step outranks a simultaneous clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wrapped_q <= 1'b0;
        end else if (step && (count == '1)) begin
            wrapped_q <= 1'b1;
        end else if (bus.EN_clear_wrap && bus.RDY_clear_wrap) begin
            wrapped_q <= 1'b0;
        end
    end

    assign bus.wrapped = wrapped_q;
`endif

endmodule : counter_method_resp

// File: tb/tb_counter_method_resp.sv
// Bench for counter_method_resp: a stopped-at-reset instance driven with directed
// method calls and a run-at-reset instance left idle, both checked against a model.
module tb_counter_method_resp;

    localparam int W    = 4;
    localparam int PW   = 2;
    localparam int PMAX = 1 << PW;
    localparam int CMAX = 1 << W;

    logic CLK;
    logic RST;

    counter_method_resp_if #(.WIDTH(W)) if0 ();
    counter_method_resp_if #(.WIDTH(W)) if1 ();

    counter_method_resp #(.WIDTH(W), .PRESCALE_W(PW), .START_RUNNING(1'b0)) u0 (
        .CLK (CLK), .RST (RST), .bus (if0)
    );
    counter_method_resp #(.WIDTH(W), .PRESCALE_W(PW), .START_RUNNING(1'b1)) u1 (
        .CLK (CLK), .RST (RST), .bus (if1)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_on      = 1'b0;

    // Model: per instance, running flag, running cycles into the current period,
    // current count, tick of the last edge and sticky wrap flag.
    bit m_run   [2];
    int m_phase [2];
    int m_cnt   [2];
    bit m_tick  [2];
    bit m_wrap  [2];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i]   = (i == 1);
            m_phase[i] = 0;
            m_cnt[i]   = 0;
            m_tick[i]  = 1'b0;
            m_wrap[i]  = 1'b0;
        end
    endtask

    task automatic model_edge(input int i, input bit st, input bit sp, input bit ld,
                              input int lv, input bit clr);
        bit set_wrap;
        set_wrap  = 1'b0;
        m_tick[i] = 1'b0;
        if (m_run[i]) begin
            if (sp) begin
                m_run[i]   = 1'b0;
                m_phase[i] = 0;
            end else begin
                if (m_phase[i] == PMAX - 1) begin
                    m_cnt[i]  = (m_cnt[i] + 1) % CMAX;
                    m_tick[i] = 1'b1;
                    set_wrap  = (m_cnt[i] == 0);
                end
                m_phase[i] = (m_phase[i] + 1) % PMAX;
            end
        end else begin
            if (ld) m_cnt[i] = lv;
            if (st) begin
                m_run[i]   = 1'b1;
                m_phase[i] = 0;
            end
        end
        if (set_wrap)  m_wrap[i] = 1'b1;
        else if (clr)  m_wrap[i] = 1'b0;
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            model_reset();
        end else begin
`ifdef COUNTER_WRAP_FLAG_EN
            model_edge(0, if0.EN_start, if0.EN_stop, if0.EN_load, int'(if0.load_value), if0.EN_clear_wrap);
            model_edge(1, if1.EN_start, if1.EN_stop, if1.EN_load, int'(if1.load_value), if1.EN_clear_wrap);
`else
            model_edge(0, if0.EN_start, if0.EN_stop, if0.EN_load, int'(if0.load_value), 1'b0);
            model_edge(1, if1.EN_start, if1.EN_stop, if1.EN_load, int'(if1.load_value), 1'b0);
`endif
        end
    end

    task automatic compare_inst(input string tag, input int i, input logic [W-1:0] cnt,
                                input logic tck, input logic rs, input logic rp,
                                input logic rl, input logic rc);
        check({tag, ".count_value"}, 32'(cnt), 32'(m_cnt[i]));
        check({tag, ".tick"}, 32'(tck), 32'(m_tick[i]));
        check({tag, ".RDY_start"}, 32'(rs), 32'(!RST && !m_run[i]));
        check({tag, ".RDY_load"},  32'(rl), 32'(!RST && !m_run[i]));
        check({tag, ".RDY_stop"},  32'(rp), 32'(!RST && m_run[i]));
        check({tag, ".RDY_count_value"}, 32'(rc), 32'(!RST));
    endtask

    always @(negedge CLK) begin
        if (cmp_on) begin
            compare_inst("u0", 0, if0.count_value, if0.tick, if0.RDY_start, if0.RDY_stop,
                         if0.RDY_load, if0.RDY_count_value);
            compare_inst("u1", 1, if1.count_value, if1.tick, if1.RDY_start, if1.RDY_stop,
                         if1.RDY_load, if1.RDY_count_value);
`ifdef COUNTER_WRAP_FLAG_EN
            check("u0.wrapped", 32'(if0.wrapped), 32'(m_wrap[0]));
            check("u0.RDY_clear_wrap", 32'(if0.RDY_clear_wrap), 32'(!RST));
`endif
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1;
        model_reset();
        {if0.EN_start, if0.EN_stop, if0.EN_load} = '0;
        {if1.EN_start, if1.EN_stop, if1.EN_load} = '0;
        if0.load_value = '0;
        if1.load_value = '0;
`ifdef COUNTER_WRAP_FLAG_EN
        if0.EN_clear_wrap = 1'b0;
        if1.EN_clear_wrap = 1'b0;
`endif
        @(negedge CLK);
        cmp_on = 1'b1;
        check("rst.count", 32'(if0.count_value), 32'h0);
        check("rst.rdy_cv", 32'(if0.RDY_count_value), 32'h0);
        check("rst.rdy_stop_u1", 32'(if1.RDY_stop), 32'h0);
        @(negedge CLK);
        #2 RST = 1'b0;

        // Run-at-reset instance steps after four edges with no method calls.
        wait_neg(4);
        check("autorun.count", 32'(if1.count_value), 32'h1);
        check("autorun.rdy_stop", 32'(if1.RDY_stop), 32'h1);
        check("autorun.rdy_start", 32'(if1.RDY_start), 32'h0);
        check("idle.rdy_start", 32'(if0.RDY_start), 32'h1);

        // Start, then steps at 4, 8, 12 edges after the start edge.
        if0.EN_start = 1'b1;
        wait_neg(1);
        if0.EN_start = 1'b0;
        wait_neg(3);
        check("start.pre", 32'(if0.count_value), 32'h0);
        wait_neg(1);
        check("start.s1", 32'(if0.count_value), 32'h1);
        check("start.tick", 32'(if0.tick), 32'h1);
        wait_neg(4);
        check("start.s2", 32'(if0.count_value), 32'h2);
        wait_neg(4);
        check("start.s3", 32'(if0.count_value), 32'h3);

        // Stop exactly when a step is due.
        wait_neg(3);
        if0.EN_stop = 1'b1;
        wait_neg(1);
        if0.EN_stop = 1'b0;
        check("stop.count", 32'(if0.count_value), 32'h3);
        check("stop.tick", 32'(if0.tick), 32'h0);
        check("stop.rdy_start", 32'(if0.RDY_start), 32'h1);
        wait_neg(5);
        check("stop.held", 32'(if0.count_value), 32'h3);

        // Restart: next step a full period later.
        if0.EN_start = 1'b1;
        wait_neg(1);
        if0.EN_start = 1'b0;
        wait_neg(3);
        check("restart.pre", 32'(if0.count_value), 32'h3);
        wait_neg(1);
        check("restart.step", 32'(if0.count_value), 32'h4);

        // Load and start while running are ignored.
        if0.EN_load    = 1'b1;
        if0.load_value = 4'h5;
        if0.EN_start   = 1'b1;
        wait_neg(1);
        {if0.EN_load, if0.EN_start} = '0;
        check("runload.ignored", 32'(if0.count_value), 32'h4);
        wait_neg(3);
        check("runload.step", 32'(if0.count_value), 32'h5);

        // Reach 7 then assert reset between clock edges.
        wait_neg(8);
        check("pre_rst.count", 32'(if0.count_value), 32'h7);
        wait_neg(1);
        #2 RST = 1'b1;
        #1;
        check("async.count", 32'(if0.count_value), 32'h0);
        check("async.rdy_stop", 32'(if0.RDY_stop), 32'h0);
        check("async.rdy_start", 32'(if0.RDY_start), 32'h0);
        check("async.rdy_load", 32'(if0.RDY_load), 32'h0);
        check("async.rdy_cv", 32'(if0.RDY_count_value), 32'h0);
        check("async.u1_count", 32'(if1.count_value), 32'h0);
        wait_neg(1);
        #2 RST = 1'b0;
        wait_neg(3);
        check("rerun.pre", 32'(if1.count_value), 32'h0);
        wait_neg(1);
        check("rerun.step", 32'(if1.count_value), 32'h1);

        // Load E together with start, then E -> F -> 0 wrap.
        if0.EN_load    = 1'b1;
        if0.load_value = 4'hE;
        if0.EN_start   = 1'b1;
        wait_neg(1);
        {if0.EN_load, if0.EN_start} = '0;
        check("wrap.load", 32'(if0.count_value), 32'hE);
        check("wrap.running", 32'(if0.RDY_stop), 32'h1);
        wait_neg(4);
        check("wrap.f", 32'(if0.count_value), 32'hF);
        wait_neg(4);
        check("wrap.zero", 32'(if0.count_value), 32'h0);
        check("wrap.tick", 32'(if0.tick), 32'h1);
`ifdef COUNTER_WRAP_FLAG_EN
        check("wrap.flag", 32'(if0.wrapped), 32'h1);
        if0.EN_clear_wrap = 1'b1;
        wait_neg(1);
        if0.EN_clear_wrap = 1'b0;
        check("wrap.cleared", 32'(if0.wrapped), 32'h0);
`endif

        // Stop, then load while stopped; stop while stopped is ignored.
        if0.EN_stop = 1'b1;
        wait_neg(1);
        if0.EN_stop    = 1'b0;
        if0.EN_load    = 1'b1;
        if0.EN_stop    = 1'b1;
        if0.load_value = 4'h9;
        wait_neg(1);
        {if0.EN_load, if0.EN_stop} = '0;
        check("stopload.count", 32'(if0.count_value), 32'h9);
        check("stopload.rdy_stop", 32'(if0.RDY_stop), 32'h0);
        wait_neg(6);
        check("stopload.frozen", 32'(if0.count_value), 32'h9);

        cmp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_counter_method_resp
